// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog reset-request generator.
// Contents: FSM state enum (IDLE, RUN, FIRE) and 50 MHz default timing values.
// Imported by wdt_rst_req.
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIRE = 2'd2
  } wdt_state_t;

  // 100 ms at 50 MHz
  localparam int unsigned TIMEOUT_CYCLES_100MS = 5_000_000;
  // 20 us reset-request pulse at 50 MHz
  localparam int unsigned PULSE_CYCLES_DEF     = 1_000;
  // 10 ms early warning at 50 MHz
  localparam int unsigned WARN_CYCLES_DEF      = 500_000;
  // wide enough for TIMEOUT_CYCLES_100MS
  localparam int unsigned CNT_W_DEF            = 25;

endpackage

// File: rtl/wdt_rst_req.sv
// Watchdog reset-request generator: counts cycles while enabled, fires a
// fixed-width active-low reset-request pulse if not kicked within the timeout.
// Latency: rst_req_n falls at the edge ending RUN cycle TIMEOUT_CYCLES-1, held
// low PULSE_CYCLES cycles; no backpressure (kick/en ignored during the pulse).
//
// Ports:
//   clk_50m    in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   watchdog enable (level)
//   kick       in   single-cycle restart pulse
//   rst_req_n  out  registered active-low reset request, resets to 1
//   fired      out  sticky expiry flag, cleared by disable or reset
//   warn       out  early warning (only with WDT_WARN_EN, else constant 0)
//
// Optional feature macro: WDT_WARN_EN enables the early-warning comparator.
module wdt_rst_req
  import wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_100MS,
  parameter int unsigned PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int unsigned WARN_CYCLES    = WARN_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic rst_req_n,
  output logic fired,
  output logic warn
);

  // Reject illegal configurations while elaborating.
  if ((CNT_W < 1) || (CNT_W > 32) ||
      (TIMEOUT_CYCLES < 2) || (PULSE_CYCLES < 1) ||
      (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(PULSE_CYCLES) >= (64'd1 << CNT_W)) ||
      (WARN_CYCLES >= TIMEOUT_CYCLES)) begin : g_bad_params
    $fatal(1, "wdt_rst_req: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);

  wdt_state_t       state;
  logic [CNT_W-1:0] cnt;

  // One counter serves both the timeout (RUN) and the pulse width (FIRE).
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rst_req_n <= 1'b1;
      fired     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= RUN;
          end else begin
            fired <= 1'b0;
          end
        end

        RUN: begin
          // Priority: disable, then kick, then timeout. A kick on the final
          // count therefore still prevents the fire.
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            fired <= 1'b0;
          end else if (kick) begin
            cnt <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state     <= FIRE;
            cnt       <= '0;
            rst_req_n <= 1'b0;
            fired     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        FIRE: begin
          // The pulse always runs to completion; only rst_n can cut it short.
          if (cnt == PULSE_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            rst_req_n <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rst_req_n <= 1'b1;
        end
      endcase
    end
  end

`ifdef WDT_WARN_EN
  localparam logic [CNT_W-1:0] WARN_START = CNT_W'(TIMEOUT_CYCLES - WARN_CYCLES);

  // Decoded straight from the registered count, so it drops the cycle after
  // a kick, a disable or entry to FIRE.
  assign warn = (state == RUN) && (cnt >= WARN_START);
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_rst_req.sv
module tb_wdt_rst_req;
  import wdt_pkg::*;

  localparam int TO = 16;
  localparam int PL = 4;
  localparam int WN = 4;
`ifdef WDT_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic clk_50m;
  logic rst_n;
  logic en;
  logic kick;
  logic rst_req_n;
  logic fired;
  logic warn;

  wdt_rst_req #(
    .TIMEOUT_CYCLES(TO),
    .PULSE_CYCLES  (PL),
    .WARN_CYCLES   (WN),
    .CNT_W         (8)
  ) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .en       (en),
    .kick     (kick),
    .rst_req_n(rst_req_n),
    .fired    (fired),
    .warn     (warn)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model of the watchdog, advanced once per driven cycle.
  typedef struct {
    bit         rq;
    bit         fired;
    bit         warn;
    int         cnt;
    wdt_state_t st;
  } exp_t;

  exp_t       sb[$];
  wdt_state_t m_st  = IDLE;
  int         m_cnt = 0;
  bit         m_rq  = 1'b1;
  bit         m_fired = 1'b0;

  function void model_step(input bit r, input bit e, input bit k);
    if (!r) begin
      m_st = IDLE; m_cnt = 0; m_rq = 1'b1; m_fired = 1'b0;
    end else begin
      case (m_st)
        IDLE: begin
          m_cnt = 0;
          if (e) m_st = RUN;
          else   m_fired = 1'b0;
        end
        RUN: begin
          if (!e) begin
            m_st = IDLE; m_cnt = 0; m_fired = 1'b0;
          end else if (k) begin
            m_cnt = 0;
          end else if (m_cnt == TO - 1) begin
            m_st = FIRE; m_cnt = 0; m_rq = 1'b0; m_fired = 1'b1;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          if (m_cnt == PL - 1) begin
            m_st = IDLE; m_cnt = 0; m_rq = 1'b1;
          end else begin
            m_cnt++;
          end
        end
      endcase
    end
  endfunction

  // Drive one cycle of inputs, queue the model's prediction, compare after the edge.
  task automatic tick(input bit r, input bit e, input bit k);
    exp_t x;
    rst_n = r;
    en    = e;
    kick  = k;
    model_step(r, e, k);
    x.rq    = m_rq;
    x.fired = m_fired;
    x.warn  = WARN_ON && (m_st == RUN) && (m_cnt >= TO - WN);
    x.cnt   = m_cnt;
    x.st    = m_st;
    sb.push_back(x);
    @(posedge clk_50m);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("sb_rst_req_n", rst_req_n, x.rq);
      chk("sb_fired", fired, x.fired);
      chk("sb_warn", warn, x.warn);
      chk("sb_cnt", dut.cnt, x.cnt);
      chk("sb_state", dut.state, x.st);
    end
  endtask

  task automatic do_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
  endtask

  typedef struct {
    int len;
    bit rst_n;
    bit en;
    int kick_every;  // 0 = no kicks, N = kick on every Nth cycle of the segment
    bit exp_rq;
    bit exp_fired;
    int exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    kick  = 1'b0;

    vecs[0]  = '{2,   0, 0, 0,  1, 0, 0};   // reset state
    vecs[1]  = '{1,   1, 1, 0,  1, 0, 0};   // IDLE -> RUN, cnt 0
    vecs[2]  = '{200, 1, 1, 10, 1, 0, 0};   // kicked every 10 cycles
    vecs[3]  = '{1,   1, 0, 0,  1, 0, 0};   // disable
    vecs[4]  = '{5,   1, 0, 0,  1, 0, 0};
    vecs[5]  = '{1,   1, 1, 0,  1, 0, 0};   // re-enable
    vecs[6]  = '{10,  1, 1, 0,  1, 0, 10};
    vecs[7]  = '{5,   1, 1, 0,  1, 0, 15};  // final count
    vecs[8]  = '{1,   1, 1, 0,  0, 1, 0};   // fires
    vecs[9]  = '{3,   1, 1, 1,  0, 1, 3};   // kicks ignored in FIRE
    vecs[10] = '{1,   1, 0, 0,  1, 1, 0};   // pulse ends, en ignored, fired kept
    vecs[11] = '{1,   1, 0, 0,  1, 0, 0};   // disable in IDLE clears fired

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        int ke;
        ke = vecs[v].kick_every;
        tick(vecs[v].rst_n, vecs[v].en, (ke != 0) && ((i % ke) == ke - 1));
      end
      chk($sformatf("vec%0d_rst_req_n", v), rst_req_n, vecs[v].exp_rq);
      chk($sformatf("vec%0d_fired", v), fired, vecs[v].exp_fired);
      chk($sformatf("vec%0d_cnt", v), dut.cnt, vecs[v].exp_cnt);
    end

    // No kick: pulse occupies RUN cycles 16..19, IDLE at 20, RUN again at 21.
    do_reset();
    for (int k = 0; k <= 21; k++) begin
      tick(1, 1, 0);
      chk($sformatf("nokick_rq_c%0d", k), rst_req_n, !((k >= 16) && (k <= 19)));
      chk($sformatf("nokick_fired_c%0d", k), fired, (k >= 16));
      if (k == 20) chk("nokick_idle_c20", dut.state, IDLE);
      if (k == 21) begin
        chk("nokick_run_c21", dut.state, RUN);
        chk("nokick_cnt_c21", dut.cnt, 0);
      end
    end

    // Kick on the final count prevents the fire; next fire 16 cycles later.
    do_reset();
    tick(1, 1, 0);
    repeat (15) tick(1, 1, 0);
    chk("lastkick_cnt15", dut.cnt, 15);
    tick(1, 1, 1);
    chk("lastkick_cnt0", dut.cnt, 0);
    chk("lastkick_rq", rst_req_n, 1);
    repeat (15) tick(1, 1, 0);
    chk("lastkick_rq_before", rst_req_n, 1);
    tick(1, 1, 0);
    chk("lastkick_rq_fire", rst_req_n, 0);
    chk("lastkick_fired", fired, 1);
    repeat (4) tick(1, 1, 0);

    // Disable at cnt 8, re-enable 5 cycles later; full timeout from re-entry.
    do_reset();
    tick(1, 1, 0);
    repeat (8) tick(1, 1, 0);
    chk("endrop_cnt8", dut.cnt, 8);
    tick(1, 0, 0);
    chk("endrop_idle", dut.state, IDLE);
    repeat (4) tick(1, 0, 0);
    tick(1, 1, 0);
    chk("endrop_reentry_cnt", dut.cnt, 0);
    chk("endrop_reentry_run", dut.state, RUN);
    repeat (15) tick(1, 1, 0);
    chk("endrop_rq_before", rst_req_n, 1);
    tick(1, 1, 0);
    chk("endrop_rq_fire", rst_req_n, 0);

    // Reset during FIRE cycle 2 aborts the pulse at the next edge.
    do_reset();
    tick(1, 1, 0);
    repeat (16) tick(1, 1, 0);
    chk("midfire_rq_low", rst_req_n, 0);
    repeat (2) tick(1, 1, 0);
    chk("midfire_cnt2", dut.cnt, 2);
    tick(0, 1, 0);
    chk("midfire_rst_rq", rst_req_n, 1);
    chk("midfire_rst_fired", fired, 0);
    tick(1, 0, 0);
    chk("midfire_release_idle", dut.state, IDLE);
    chk("midfire_release_rq", rst_req_n, 1);

    // Early warning: rises at cnt 12, cleared by a kick at cnt 13.
    do_reset();
    tick(1, 1, 0);
    repeat (11) tick(1, 1, 0);
    chk("warn_cnt11", warn, 0);
    tick(1, 1, 0);
    chk("warn_cnt12", warn, WARN_ON);
    tick(1, 1, 0);
    chk("warn_cnt13", warn, WARN_ON);
    tick(1, 1, 1);
    chk("warn_after_kick", warn, 0);
    repeat (10) tick(1, 1, 0);
    chk("warn_kick_rq", rst_req_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
